// File: rtl/mem_arb_pkg.sv
// rtl/mem_arb_pkg.sv - shared types and constants for the unified memory port arbiter
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2
  } state_e;

  typedef enum logic {
    OWN_IF  = 1'b0,
    OWN_MEM = 1'b1
  } owner_e;

  localparam logic [1:0] SZ_B = 2'd0;
  localparam logic [1:0] SZ_H = 2'd1;
  localparam logic [1:0] SZ_W = 2'd2;
  localparam logic [1:0] SZ_D = 2'd3;

  localparam int DEF_STARVE_LIMIT = 4;
  localparam int DEF_TIMEOUT      = 255;

endpackage

// File: rtl/arb_starve_select.sv
// rtl/arb_starve_select.sv - fetch/data winner selection with saturating starve counter
module arb_starve_select
  import mem_arb_pkg::*;
#(
  parameter int STARVE_LIMIT = DEF_STARVE_LIMIT
) (
  input  logic clk,
  input  logic reset,
  input  logic i_arb,
  input  logic i_if_req,
  input  logic i_mem_req,
  output logic o_if_win
);

  logic [3:0] r_starve_cnt;
  logic       w_starved;

  assign w_starved = (r_starve_cnt == 4'(STARVE_LIMIT));
  // Fetch only wins while it is actually requesting, so a stale count never grants an idle port.
  assign o_if_win  = i_if_req && (!i_mem_req || w_starved);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_starve_cnt <= '0;
    end else if (i_arb) begin
      if (o_if_win) begin
        r_starve_cnt <= '0;
      end else if (i_if_req && !w_starved) begin
        r_starve_cnt <= r_starve_cnt + 4'd1;
      end
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - fetch/data arbiter onto one memory port; MEM_PORT_ARBITER_PERF_CNT_EN adds perf counters
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W       = 64,
  parameter int DATA_W       = 64,
  parameter int INST_W       = 32,
  parameter int STARVE_LIMIT = DEF_STARVE_LIMIT,
  parameter int TIMEOUT      = DEF_TIMEOUT
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              IF_REQ,
  input  logic [ADDR_W-1:0] IF_ADDR,
  output logic              IF_GNT,
  output logic              IF_RVALID,
  output logic [INST_W-1:0] IF_RDATA,
  input  logic              MEM_REQ,
  input  logic              MEM_WE,
  input  logic [1:0]        MEM_SIZE,
  input  logic [ADDR_W-1:0] MEM_ADDR,
  input  logic [DATA_W-1:0] MEM_WDATA,
  output logic              MEM_GNT,
  output logic              MEM_RVALID,
  output logic [DATA_W-1:0] MEM_RDATA,
  output logic              BUS_ERR,
  output logic              M_VALID,
  input  logic              M_READY,
  output logic              M_WE,
  output logic [1:0]        M_SIZE,
  output logic [ADDR_W-1:0] M_ADDR,
  output logic [DATA_W-1:0] M_WDATA,
  input  logic              M_RVALID,
  input  logic [DATA_W-1:0] M_RDATA,
  output logic [31:0]       PERF_IF_GNT,
  output logic [31:0]       PERF_MEM_GNT,
  output logic [31:0]       PERF_IF_STALL
);

  state_e     r_state;
  state_e     w_state_nxt;
  owner_e     r_owner;
  logic       r_addr2;
  logic [7:0] r_tcnt;
  logic       w_arb;
  logic       w_if_win;
  logic       w_done;
  logic       w_rsp;
  logic       w_tmo;

  assign w_arb  = (r_state == IDLE) && (IF_REQ || MEM_REQ);
  // The RVALID cycle is spent in WAIT so the next arbitration starts one cycle later.
  assign w_done = IF_RVALID || MEM_RVALID;
  assign w_rsp  = (r_state == WAIT) && !w_done && M_RVALID;
  assign w_tmo  = (r_state == WAIT) && !w_done && !M_RVALID && (r_tcnt == 8'(TIMEOUT - 1));

  arb_starve_select #(
    .STARVE_LIMIT(STARVE_LIMIT)
  ) u_select (
    .clk      (CLK),
    .reset    (RESET),
    .i_arb    (w_arb),
    .i_if_req (IF_REQ),
    .i_mem_req(MEM_REQ),
    .o_if_win (w_if_win)
  );

  always_ff @(posedge CLK) begin
    if (RESET) r_state <= IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (IF_REQ || MEM_REQ) w_state_nxt = ISSUE;
      ISSUE:   if (M_READY) w_state_nxt = WAIT;
      WAIT:    if (w_done) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      IF_GNT     <= 1'b0;
      IF_RVALID  <= 1'b0;
      IF_RDATA   <= '0;
      MEM_GNT    <= 1'b0;
      MEM_RVALID <= 1'b0;
      MEM_RDATA  <= '0;
      BUS_ERR    <= 1'b0;
      M_VALID    <= 1'b0;
      M_WE       <= 1'b0;
      M_SIZE     <= '0;
      M_ADDR     <= '0;
      M_WDATA    <= '0;
      r_owner    <= OWN_IF;
      r_addr2    <= 1'b0;
      r_tcnt     <= '0;
    end else begin
      IF_GNT     <= 1'b0;
      MEM_GNT    <= 1'b0;
      IF_RVALID  <= 1'b0;
      MEM_RVALID <= 1'b0;
      BUS_ERR    <= 1'b0;
      if (w_arb) begin
        M_VALID <= 1'b1;
        if (w_if_win) begin
          r_owner <= OWN_IF;
          IF_GNT  <= 1'b1;
          M_WE    <= 1'b0;
          M_SIZE  <= SZ_W;
          M_ADDR  <= IF_ADDR;
          M_WDATA <= '0;
          r_addr2 <= IF_ADDR[2];
        end else begin
          r_owner <= OWN_MEM;
          MEM_GNT <= 1'b1;
          M_WE    <= MEM_WE;
          M_SIZE  <= MEM_SIZE;
          M_ADDR  <= MEM_ADDR;
          M_WDATA <= MEM_WDATA;
        end
      end
      if ((r_state == ISSUE) && M_READY) begin
        M_VALID <= 1'b0;
        r_tcnt  <= '0;
      end else if (r_state == WAIT) begin
        r_tcnt <= r_tcnt + 8'd1;
      end
      if (w_rsp || w_tmo) begin
        BUS_ERR <= w_tmo;
        if (r_owner == OWN_IF) begin
          IF_RVALID <= 1'b1;
          IF_RDATA  <= w_tmo ? '0 : (r_addr2 ? M_RDATA[INST_W +: INST_W] : M_RDATA[INST_W-1:0]);
        end else begin
          MEM_RVALID <= 1'b1;
          MEM_RDATA  <= (w_tmo || M_WE) ? '0 : M_RDATA;
        end
      end
    end
  end

`ifdef MEM_PORT_ARBITER_PERF_CNT_EN
  logic [31:0] r_perf_if_gnt;
  logic [31:0] r_perf_mem_gnt;
  logic [31:0] r_perf_if_stall;

  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_perf_if_gnt   <= '0;
      r_perf_mem_gnt  <= '0;
      r_perf_if_stall <= '0;
    end else begin
      if (IF_GNT)            r_perf_if_gnt   <= r_perf_if_gnt + 32'd1;
      if (MEM_GNT)           r_perf_mem_gnt  <= r_perf_mem_gnt + 32'd1;
      if (IF_REQ && !IF_GNT) r_perf_if_stall <= r_perf_if_stall + 32'd1;
    end
  end

  assign PERF_IF_GNT   = r_perf_if_gnt;
  assign PERF_MEM_GNT  = r_perf_mem_gnt;
  assign PERF_IF_STALL = r_perf_if_stall;
`else
  assign PERF_IF_GNT   = '0;
  assign PERF_MEM_GNT  = '0;
  assign PERF_IF_STALL = '0;
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - directed self-checking bench for mem_port_arbiter
module tb_mem_port_arbiter;

  logic        CLK = 1'b0;
  logic        RESET;
  logic        IF_REQ;
  logic [63:0] IF_ADDR;
  logic        IF_GNT;
  logic        IF_RVALID;
  logic [31:0] IF_RDATA;
  logic        MEM_REQ;
  logic        MEM_WE;
  logic [1:0]  MEM_SIZE;
  logic [63:0] MEM_ADDR;
  logic [63:0] MEM_WDATA;
  logic        MEM_GNT;
  logic        MEM_RVALID;
  logic [63:0] MEM_RDATA;
  logic        BUS_ERR;
  logic        M_VALID;
  logic        M_READY;
  logic        M_WE;
  logic [1:0]  M_SIZE;
  logic [63:0] M_ADDR;
  logic [63:0] M_WDATA;
  logic        M_RVALID;
  logic [63:0] M_RDATA;
  logic [31:0] PERF_IF_GNT;
  logic [31:0] PERF_MEM_GNT;
  logic [31:0] PERF_IF_STALL;

  int checks   = 0;
  int failures = 0;

  mem_port_arbiter #(
    .ADDR_W(64), .DATA_W(64), .INST_W(32), .STARVE_LIMIT(4), .TIMEOUT(8)
  ) dut (
    .CLK(CLK), .RESET(RESET),
    .IF_REQ(IF_REQ), .IF_ADDR(IF_ADDR), .IF_GNT(IF_GNT),
    .IF_RVALID(IF_RVALID), .IF_RDATA(IF_RDATA),
    .MEM_REQ(MEM_REQ), .MEM_WE(MEM_WE), .MEM_SIZE(MEM_SIZE), .MEM_ADDR(MEM_ADDR),
    .MEM_WDATA(MEM_WDATA), .MEM_GNT(MEM_GNT), .MEM_RVALID(MEM_RVALID),
    .MEM_RDATA(MEM_RDATA), .BUS_ERR(BUS_ERR),
    .M_VALID(M_VALID), .M_READY(M_READY), .M_WE(M_WE), .M_SIZE(M_SIZE),
    .M_ADDR(M_ADDR), .M_WDATA(M_WDATA), .M_RVALID(M_RVALID), .M_RDATA(M_RDATA),
    .PERF_IF_GNT(PERF_IF_GNT), .PERF_MEM_GNT(PERF_MEM_GNT), .PERF_IF_STALL(PERF_IF_STALL)
  );

  always #5 CLK = ~CLK;

  task automatic tick;
    @(posedge CLK);
    #1;
  endtask

  task automatic test_reset;
    logic [5:0] flags;
    RESET = 1'b1; IF_REQ = 0; IF_ADDR = '0; MEM_REQ = 0; MEM_WE = 0; MEM_SIZE = 0;
    MEM_ADDR = '0; MEM_WDATA = '0; M_READY = 0; M_RVALID = 0; M_RDATA = '0;
    tick(); tick();
    flags = {IF_GNT, IF_RVALID, MEM_GNT, MEM_RVALID, BUS_ERR, M_VALID};
    checks++;
    if (flags !== 6'b0) begin failures++; $display("FAIL reset_flags got=%b exp=000000", flags); end
    checks++;
    if ({M_ADDR, M_WDATA, MEM_RDATA} !== 192'b0 || IF_RDATA !== 32'b0 || M_WE !== 1'b0 || M_SIZE !== 2'b0) begin
      failures++; $display("FAIL reset_data got=%h/%h/%h/%h exp=0", M_ADDR, M_WDATA, MEM_RDATA, IF_RDATA);
    end
    checks++;
    if ({PERF_IF_GNT, PERF_MEM_GNT, PERF_IF_STALL} !== 96'b0) begin
      failures++; $display("FAIL reset_perf got=%h exp=0", {PERF_IF_GNT, PERF_MEM_GNT, PERF_IF_STALL});
    end
    RESET = 1'b0;
    tick();
  endtask

  task automatic test_fetch_only;
    IF_REQ = 1; IF_ADDR = 64'h1004; M_READY = 1;
    tick();
    checks++;
    if ({IF_GNT, MEM_GNT, M_VALID, M_WE, M_SIZE} !== 6'b101010 || M_ADDR !== 64'h1004 || M_WDATA !== 64'h0) begin
      failures++; $display("FAIL fetch_issue got=%b addr=%h exp=101010 addr=1004", {IF_GNT, MEM_GNT, M_VALID, M_WE, M_SIZE}, M_ADDR);
    end
    IF_REQ = 0;
    tick();
    checks++;
    if (M_VALID !== 1'b0 || IF_RVALID !== 1'b0) begin
      failures++; $display("FAIL fetch_wait got=%b%b exp=00", M_VALID, IF_RVALID);
    end
    M_RVALID = 1; M_RDATA = 64'hAAAA_BBBB_CCCC_DDDD;
    tick();
    checks++;
    if (IF_RVALID !== 1'b1 || IF_RDATA !== 32'hAAAABBBB || BUS_ERR !== 1'b0 || MEM_RVALID !== 1'b0) begin
      failures++; $display("FAIL fetch_rsp got=%b %h exp=1 aaaabbbb", IF_RVALID, IF_RDATA);
    end
    M_RVALID = 0;
    tick();
    checks++;
    if (IF_RVALID !== 1'b0) begin failures++; $display("FAIL fetch_pulse got=%b exp=0", IF_RVALID); end
  endtask

  task automatic test_simultaneous;
    IF_REQ = 1; IF_ADDR = 64'h2008;
    MEM_REQ = 1; MEM_WE = 0; MEM_SIZE = 2'd3; MEM_ADDR = 64'h2000; M_READY = 1;
    tick();
    checks++;
    if (MEM_GNT !== 1'b1 || IF_GNT !== 1'b0 || M_ADDR !== 64'h2000 || M_SIZE !== 2'd3) begin
      failures++; $display("FAIL simul_first got=mem%b if%b addr=%h exp=mem1 if0 addr=2000", MEM_GNT, IF_GNT, M_ADDR);
    end
    MEM_REQ = 0;
    tick();
    M_RVALID = 1; M_RDATA = 64'h1122_3344_5566_7788;
    tick();
    checks++;
    if (MEM_RVALID !== 1'b1 || MEM_RDATA !== 64'h1122_3344_5566_7788 || IF_RVALID !== 1'b0) begin
      failures++; $display("FAIL simul_load got=%b %h exp=1 1122334455667788", MEM_RVALID, MEM_RDATA);
    end
    M_RVALID = 0;
    tick();
    checks++;
    if (IF_GNT !== 1'b0) begin failures++; $display("FAIL simul_gap got=%b exp=0", IF_GNT); end
    tick();
    checks++;
    if (IF_GNT !== 1'b1 || M_ADDR !== 64'h2008) begin
      failures++; $display("FAIL simul_fetch got=%b addr=%h exp=1 addr=2008", IF_GNT, M_ADDR);
    end
    IF_REQ = 0;
    tick();
    M_RVALID = 1; M_RDATA = 64'hAAAA_BBBB_CCCC_DDDD;
    tick();
    checks++;
    if (IF_RVALID !== 1'b1 || IF_RDATA !== 32'hCCCCDDDD) begin
      failures++; $display("FAIL simul_lowword got=%b %h exp=1 ccccdddd", IF_RVALID, IF_RDATA);
    end
    M_RVALID = 0;
    tick();
  endtask

  task automatic test_starvation;
    logic exp_if;
    IF_REQ = 1; IF_ADDR = 64'h3000;
    MEM_REQ = 1; MEM_WE = 0; MEM_SIZE = 2'd3; MEM_ADDR = 64'h4000;
    M_READY = 1; M_RVALID = 1; M_RDATA = 64'h0123_4567_89AB_CDEF;
    for (int i = 0; i < 6; i++) begin
      exp_if = (i == 4);
      tick();
      checks++;
      if (IF_GNT !== exp_if || MEM_GNT !== !exp_if || M_ADDR !== (exp_if ? 64'h3000 : 64'h4000)) begin
        failures++; $display("FAIL starve_grant%0d got=if%b mem%b exp=if%b", i, IF_GNT, MEM_GNT, exp_if);
      end
      if (IF_GNT) IF_REQ = 0;
      tick();
      tick();
      checks++;
      if ((exp_if ? IF_RVALID : MEM_RVALID) !== 1'b1) begin
        failures++; $display("FAIL starve_rsp%0d got=if%b mem%b exp=1", i, IF_RVALID, MEM_RVALID);
      end
      tick();
    end
    MEM_REQ = 0; M_RVALID = 0;
    tick();
  endtask

  task automatic test_timeout;
    MEM_REQ = 1; MEM_WE = 0; MEM_SIZE = 2'd3; MEM_ADDR = 64'h6000;
    M_READY = 1; M_RVALID = 0; M_RDATA = 64'hBAD0_BAD0_BAD0_BAD0;
    tick();
    MEM_REQ = 0;
    tick();
    for (int i = 0; i < 7; i++) begin
      tick();
      checks++;
      if (MEM_RVALID !== 1'b0 || BUS_ERR !== 1'b0) begin
        failures++; $display("FAIL tmo_early%0d got=%b%b exp=00", i, MEM_RVALID, BUS_ERR);
      end
    end
    tick();
    checks++;
    if (MEM_RVALID !== 1'b1 || BUS_ERR !== 1'b1 || MEM_RDATA !== 64'h0 || IF_RVALID !== 1'b0) begin
      failures++; $display("FAIL tmo_err got=%b%b %h exp=11 0", MEM_RVALID, BUS_ERR, MEM_RDATA);
    end
    tick();
    checks++;
    if (MEM_RVALID !== 1'b0 || BUS_ERR !== 1'b0) begin
      failures++; $display("FAIL tmo_pulse got=%b%b exp=00", MEM_RVALID, BUS_ERR);
    end
  endtask

  task automatic test_store;
    MEM_REQ = 1; MEM_WE = 1; MEM_SIZE = 2'd1; MEM_ADDR = 64'h5000; MEM_WDATA = 64'h55AA;
    M_READY = 0; M_RVALID = 0;
    tick();
    checks++;
    if (MEM_GNT !== 1'b1 || M_VALID !== 1'b1 || M_WE !== 1'b1 || M_SIZE !== 2'd1 || M_WDATA !== 64'h55AA) begin
      failures++; $display("FAIL store_issue got=%b%b%b %0d %h exp=111 1 55aa", MEM_GNT, M_VALID, M_WE, M_SIZE, M_WDATA);
    end
    MEM_REQ = 0; MEM_WE = 0; MEM_SIZE = 2'd0; MEM_WDATA = 64'hDEAD;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (M_VALID !== 1'b1 || M_WE !== 1'b1 || M_SIZE !== 2'd1 || M_WDATA !== 64'h55AA || M_ADDR !== 64'h5000) begin
        failures++; $display("FAIL store_hold%0d got=%b%b %0d %h exp=11 1 55aa", i, M_VALID, M_WE, M_SIZE, M_WDATA);
      end
    end
    M_READY = 1;
    tick();
    checks++;
    if (M_VALID !== 1'b0) begin failures++; $display("FAIL store_accept got=%b exp=0", M_VALID); end
    M_RVALID = 1; M_RDATA = 64'hFFFF_FFFF_FFFF_FFFF;
    tick();
    checks++;
    if (MEM_RVALID !== 1'b1 || MEM_RDATA !== 64'h0 || BUS_ERR !== 1'b0) begin
      failures++; $display("FAIL store_ack got=%b %h exp=1 0", MEM_RVALID, MEM_RDATA);
    end
    M_RVALID = 0;
    tick();
  endtask

  task automatic test_reset_mid_wait;
    MEM_REQ = 1; MEM_WE = 0; MEM_SIZE = 2'd3; MEM_ADDR = 64'h7000; M_READY = 1; M_RVALID = 0;
    tick();
    MEM_REQ = 0;
    tick();
    tick();
    RESET = 1;
    tick();
    checks++;
    if ({M_VALID, MEM_GNT, MEM_RVALID, IF_RVALID, BUS_ERR} !== 5'b0 || M_ADDR !== 64'h0 || MEM_RDATA !== 64'h0) begin
      failures++; $display("FAIL rstwait_clear got=%b addr=%h exp=00000 addr=0", {M_VALID, MEM_GNT, MEM_RVALID, IF_RVALID, BUS_ERR}, M_ADDR);
    end
    RESET = 0; M_RVALID = 1; M_RDATA = 64'h1234;
    tick();
    checks++;
    if (MEM_RVALID !== 1'b0 || IF_RVALID !== 1'b0 || BUS_ERR !== 1'b0) begin
      failures++; $display("FAIL rstwait_late got=%b%b%b exp=000", MEM_RVALID, IF_RVALID, BUS_ERR);
    end
    M_RVALID = 0; IF_REQ = 1; IF_ADDR = 64'h100;
    tick();
    checks++;
    if (IF_GNT !== 1'b1 || M_ADDR !== 64'h100) begin
      failures++; $display("FAIL rstwait_idle got=%b addr=%h exp=1 addr=100", IF_GNT, M_ADDR);
    end
    IF_REQ = 0;
  endtask

  initial begin
    test_reset();
    test_fetch_only();
    test_simultaneous();
    test_starvation();
    test_timeout();
    test_store();
    test_reset_mid_wait();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one single-ported unified memory between two requesters: the fetch stage (instruction reads) and the memory stage (data loads/stores).
- Data requests normally win over fetch. A starvation counter guarantees fetch progress.
- One transaction is in flight at a time. A response timeout protects the pipeline from a hung memory.
- Sits between the fetch/memory pipeline stages and the external memory model.

Parameters:
- ADDR_W, 64, address width of all address ports
- DATA_W, 64, memory data width
- INST_W, 32, instruction width returned to fetch
- STARVE_LIMIT, 4, consecutive data-stage wins while fetch is pending before fetch is forced to win (legal range 1..15)
- TIMEOUT, 255, maximum cycles in WAIT before a bus error is declared (legal range 1..255)

Ports:
- CLK  in  1  clock; all logic on the rising edge
- RESET  in  1  synchronous, active-high reset
- IF_REQ  in  1  fetch read request; held until IF_GNT
- IF_ADDR  in  ADDR_W  fetch address; 4-byte aligned; held until IF_GNT
- IF_GNT  out  1  one-cycle pulse: fetch request accepted
- IF_RVALID  out  1  one-cycle pulse: IF_RDATA valid
- IF_RDATA  out  INST_W  instruction word
- MEM_REQ  in  1  data request; held until MEM_GNT
- MEM_WE  in  1  1 = store, 0 = load
- MEM_SIZE  in  2  0 = byte, 1 = half, 2 = word, 3 = dword
- MEM_ADDR  in  ADDR_W  data address
- MEM_WDATA  in  DATA_W  store data
- MEM_GNT  out  1  one-cycle pulse: data request accepted
- MEM_RVALID  out  1  one-cycle pulse: load data valid or store acknowledged
- MEM_RDATA  out  DATA_W  load data; 0 for stores
- BUS_ERR  out  1  one-cycle pulse, coincident with the owner's RVALID, on timeout
- M_VALID  out  1  command valid to memory
- M_READY  in  1  memory accepts the command
- M_WE  out  1  command write enable
- M_SIZE  out  2  command size
- M_ADDR  out  ADDR_W  command address
- M_WDATA  out  DATA_W  command write data
- M_RVALID  in  1  memory response, or write acknowledge
- M_RDATA  in  DATA_W  memory response data

Behaviour:
- Reset value of every output: 0. Reset state: IDLE. Starve counter, timeout counter and owner all clear.
- A RESET asserted in any state abandons any outstanding transaction. A late M_RVALID arriving after reset is ignored.
- All outputs are registered.

State IDLE:
- Stays in IDLE if no request is pending.
- Otherwise selects a winner:
  - Fetch wins if MEM_REQ=0, or if starve count == STARVE_LIMIT.
  - Otherwise the data stage wins.
- Latches the winner's command fields and owner into registers.
- Next cycle: M_VALID=1 and the winner's GNT pulses; state becomes ISSUE.
- A fetch command is issued as size=2, we=0, wdata=0.
- Starve counter:
  - Increments when the data stage wins while IF_REQ=1.
  - Clears when fetch wins.
  - Saturates at STARVE_LIMIT.

State ISSUE:
- Holds M_VALID and all command fields stable until M_READY=1.
- On M_READY=1: M_VALID drops next cycle; state becomes WAIT; timeout counter clears.

State WAIT:
- On M_RVALID=1, next cycle the owner's RVALID pulses, then the state returns to IDLE.
- Fetch response: IF_RDATA = M_RDATA[63:32] if the latched address bit 2 = 1, else M_RDATA[31:0].
- Load response: MEM_RDATA = M_RDATA, unmodified. Sign/zero extension belongs to the memory stage.
- Store response: MEM_RDATA = 0.
- The timeout counter increments each WAIT cycle. If it reaches TIMEOUT with no M_RVALID, the next cycle carries the owner's RVALID=1, RDATA=0 and BUS_ERR=1; then the state returns to IDLE.
- If M_RVALID and the timeout coincide, M_RVALID wins and there is no error.

Ignored and simultaneous events:
- M_RVALID is ignored in IDLE and ISSUE.
- Requests are ignored outside IDLE.
- GNT is never asserted for a requester whose REQ was low at arbitration.

Latency:
- Minimum from request to RVALID: 3 cycles, when M_READY=1 at issue and M_RVALID arrives on the first WAIT cycle.
- Back-to-back throughput: one transaction per 4 cycles minimum.

Optional Feature:
- Macro: MEM_PORT_ARBITER_PERF_CNT_EN.
- With the macro defined, three 32-bit wrapping counters are exposed as output ports PERF_IF_GNT, PERF_MEM_GNT and PERF_IF_STALL:
  - PERF_IF_GNT counts fetch grants.
  - PERF_MEM_GNT counts data grants.
  - PERF_IF_STALL counts cycles with IF_REQ=1 and no IF_GNT.
  - All three clear on RESET.
- Without the macro, the ports still exist and are tied to 0, and no counter logic is built.

Decomposition:
- Shared package mem_arb_pkg holds:
  - the state enum (IDLE, ISSUE, WAIT);
  - the owner enum (OWN_IF, OWN_MEM);
  - the size constants SZ_B, SZ_H, SZ_W, SZ_D;
  - the default STARVE_LIMIT and TIMEOUT constants.
- One sub-module, arb_starve_select, contains the winner selection logic and the saturating starve counter. The top module holds the FSM, the command and response registers, and the timeout counter.

Test Plan:
- Fetch only: IF_REQ with IF_ADDR=0x1004; memory responds on the first WAIT cycle with M_RDATA=0xAAAA_BBBB_CCCC_DDDD -> IF_GNT, and 3 cycles after request IF_RVALID with IF_RDATA=0xAAAABBBB.
- Simultaneous requests: IF_REQ and MEM_REQ (load, addr 0x2000) in the same cycle -> MEM_GNT first; fetch is granted only after the data response.
- Starvation: MEM_REQ held continuously with STARVE_LIMIT=4 and IF_REQ pending -> 4 data grants, then 1 fetch grant, then data resumes.
- Store: MEM_WE=1, MEM_SIZE=1, MEM_WDATA=0x55AA -> M_WE=1, M_SIZE=1, M_WDATA=0x55AA held through M_READY low for 3 cycles; MEM_RVALID returns with MEM_RDATA=0.
- Timeout: TIMEOUT=8 and M_RVALID never arrives -> 8 WAIT cycles, then MEM_RVALID=1, BUS_ERR=1, MEM_RDATA=0, then IDLE.
- Reset mid-WAIT: RESET pulse in WAIT, then M_RVALID the next cycle -> all outputs 0, no RVALID pulse, state IDLE.
